pattern_detect_arbiter: RTL and testbench
=========================================

PATTERN_DETECT_ARBITER -- requirements
Module: pattern_detect_arbiter

Interface
REQ-001 SHALL have parameter: CNT_W, 8, width of each per-requester hit counter (legal 2..16).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req  input  4  req[i]=1: requester i holds a byte to scan.
REQ-005 SHALL have port: req_data  input  32  requester i byte on [8i+7:8i].
REQ-006 SHALL have port: gnt  output  4  one-hot, one-cycle pulse when byte i is captured.
REQ-007 SHALL have port: det_din  output  1  serial bit to shared Moore detector.
REQ-008 SHALL have port: det_valid  output  1  qualifies det_din.
REQ-009 SHALL have port: det_flush  output  1  one-cycle pulse clearing detector history.
REQ-010 SHALL have port: det_hit  input  1  pattern-detected flag from detector.
REQ-011 SHALL have port: clr_cnt  input  1  synchronous clear of all hit counters.
REQ-012 SHALL have port: busy  output  1  high in SHIFT and DRAIN.
REQ-013 SHALL have port: hit_cnt  output  4*CNT_W  counter i on [CNT_W*(i+1)-1:CNT_W*i].

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DRAIN; one byte scan occupies exactly 10 cycles (1 IDLE grant + 8 SHIFT + 1 DRAIN).
REQ-015 IDLE with req!=0 SHALL, that cycle, pulse gnt[k] for round-robin winner k, load req_data byte k into shift register, record owner=k, enter SHIFT next cycle.
REQ-016 Round-robin SHALL search from (last_owner+1) mod 4 upward; after reset, search starts at 0.
REQ-017 IDLE with req==0 SHALL hold in IDLE, gnt=0.
REQ-018 SHIFT SHALL drive det_valid=1 and det_din=shift_reg[7] (MSB first), shifting left each cycle, for 8 cycles, then enter DRAIN.
REQ-019 DRAIN SHALL drive det_valid=0, det_din=0 for one cycle, then enter IDLE.
REQ-020 det_din SHALL be 0 whenever det_valid=0.
REQ-021 det_flush SHALL pulse in the grant cycle when new owner differs from previous owner, and on the first grant after reset; no flush when same owner re-granted.
REQ-022 det_hit=1 in any SHIFT or DRAIN cycle SHALL increment hit_cnt[owner] by 1; det_hit in IDLE SHALL be ignored.
REQ-023 clr_cnt=1 SHALL zero all counters next edge; clr_cnt with simultaneous det_hit: clear wins.
REQ-024 Changes of req or req_data after grant SHALL not affect the byte in flight.
REQ-025 busy SHALL be combinational from state (1 in SHIFT/DRAIN).

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, gnt=0, det_valid=0, det_din=0, det_flush=0, shift register 0, all hit_cnt 0, round-robin pointer to start at 0, "first grant" flag set.
REQ-027 Reset asserted mid-SHIFT SHALL abandon the byte; no counter update; det_valid low asynchronously.

Configuration
REQ-028 PD_ARB_SAT_EN defined: each counter SHALL saturate at 2^CNT_W-1; undefined: counter SHALL wrap to 0 after 2^CNT_W-1.

Verification
REQ-029 req=4'b0001, byte 8'hA5 -> gnt=0001 one cycle, det_flush=1 same cycle, det_din 1,0,1,0,0,1,0,1 with det_valid=1 for 8 cycles, then 1 DRAIN cycle, busy 9 cycles.
REQ-030 req=4'b1111 held, 8 bytes -> grant order 0,1,2,3,0,1,2,3, gnt every 10 cycles, det_flush on every grant.
REQ-031 req=4'b0100 held, 3 bytes -> gnt[2] three times, det_flush only on first grant.
REQ-032 owner 1, det_hit high in 3rd SHIFT cycle and in DRAIN -> hit_cnt[1]=2, others 0; det_hit in IDLE -> no change.
REQ-033 CNT_W=2, owner 0, 5 hits -> hit_cnt[0]=3 with PD_ARB_SAT_EN, =1 without; clr_cnt with det_hit same cycle -> 0.
REQ-034 rst=0 during 4th SHIFT cycle -> det_valid=0 before next edge, all counters 0; after release req=4'b1000 with req[0] also set -> requester 0 granted first.

Source files
------------

// File: rtl/pattern_detect_arbiter.sv
// pattern_detect_arbiter
//   Round-robin arbiter over four byte requesters. The granted byte is
//   serialised MSB-first to a shared Moore pattern detector. Detector hits
//   seen while a byte is in flight are counted per owning requester.
//
//   Each scan takes 10 cycles: 1 IDLE grant cycle, 8 SHIFT cycles, and
//   1 DRAIN cycle.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   req        per-requester "byte pending"
//   req_data   requester i byte on [8i+7:8i]
//   gnt        one-hot capture pulse (IDLE cycle, combinational)
//   det_din    serial bit to detector, 0 when det_valid is low
//   det_valid  qualifies det_din (SHIFT only)
//   det_flush  clears detector history on owner change / first grant
//   det_hit    detector match flag
//   clr_cnt    synchronous clear of all hit counters (wins over det_hit)
//   busy       high in SHIFT and DRAIN
//   hit_cnt    counter i on [CNT_W*(i+1)-1:CNT_W*i]
//
// Configuration
//   PD_ARB_SAT_EN  defined: counters saturate at all-ones
//                  undefined: counters wrap to zero
module pattern_detect_arbiter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [31:0]        req_data,
  output logic [3:0]         gnt,
  output logic               det_din,
  output logic               det_valid,
  output logic               det_flush,
  input  logic               det_hit,
  input  logic               clr_cnt,
  output logic               busy,
  output logic [4*CNT_W-1:0] hit_cnt
);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [7:0]       r_shift;
  logic [2:0]       r_bitcnt;
  logic [1:0]       r_owner;
  logic             r_first;
  logic [CNT_W-1:0] r_cnt [4];

  logic [1:0]       w_start;
  logic [1:0]       w_win;
  logic             w_found;
  logic             w_grant;

  // The search start is derived from the last owner; r_first stands in
  // for "no owner yet", so the search begins at 0 after reset.
  assign w_start = r_first ? 2'd0 : r_owner + 2'd1;

  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!w_found && req[w_start + i[1:0]]) begin
        w_found = 1'b1;
        w_win   = w_start + i[1:0];
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_grant   = 1'b0;
    gnt       = '0;
    det_flush = 1'b0;
    det_valid = 1'b0;
    det_din   = 1'b0;
    case (r_state)
      IDLE: begin
        // Grant is combinational on req; masked so it stays low during reset.
        if (w_found && rst) begin
          w_grant   = 1'b1;
          gnt       = 4'b0001 << w_win;
          det_flush = r_first || (w_win != r_owner);
          w_next    = SHIFT;
        end
      end
      SHIFT: begin
        det_valid = 1'b1;
        det_din   = r_shift[7];
        if (r_bitcnt == 3'd7) w_next = DRAIN;
      end
      DRAIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_owner  <= '0;
      r_first  <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_state <= w_next;

      if (w_grant) begin
        r_shift  <= req_data[{w_win, 3'b000} +: 8];
        r_owner  <= w_win;
        r_first  <= 1'b0;
        r_bitcnt <= '0;
      end else if (r_state == SHIFT) begin
        r_shift  <= {r_shift[6:0], 1'b0};
        r_bitcnt <= r_bitcnt + 3'd1;
      end

      if (clr_cnt) begin
        for (int unsigned i = 0; i < 4; i++) r_cnt[i] <= '0;
      end else if (r_state != IDLE && det_hit) begin
`ifdef PD_ARB_SAT_EN
        if (r_cnt[r_owner] != '1) r_cnt[r_owner] <= r_cnt[r_owner] + 1'b1;
`else
        r_cnt[r_owner] <= r_cnt[r_owner] + 1'b1;
`endif
      end
    end
  end

  assign busy = (r_state != IDLE);

  always_comb begin
    hit_cnt = '0;
    for (int unsigned i = 0; i < 4; i++) hit_cnt[CNT_W*i +: CNT_W] = r_cnt[i];
  end

endmodule

// File: tb/tb_pattern_detect_arbiter.sv
module tb_pattern_detect_arbiter;

  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    req;
  logic [31:0]   req_data;
  logic [3:0]    gnt;
  logic          det_din, det_valid, det_flush, det_hit, clr_cnt, busy;
  logic [4*CW-1:0] hit_cnt;

  pattern_detect_arbiter #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
    .det_din(det_din), .det_valid(det_valid), .det_flush(det_flush),
    .det_hit(det_hit), .clr_cnt(clr_cnt), .busy(busy), .hit_cnt(hit_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: phase 0 = waiting, 1..8 = bit (8-phase) of the captured byte on
  // the wire, 9 = drain. m_last = -1 means nobody granted since reset.
  int        m_phase = 0;
  int        m_last  = -1;
  logic [7:0] m_byte = '0;
  int        m_cnt [4] = '{0, 0, 0, 0};

  int g_log[$];
  bit din_log[$];
  int f_cnt = 0;
  int busy_cnt = 0;

  task automatic clear_logs();
    g_log.delete();
    din_log.delete();
    f_cnt    = 0;
    busy_cnt = 0;
  endtask

  always @(negedge clk) begin : cmp
    int          win;
    logic [3:0]  e_gnt;
    logic        e_flush, e_valid, e_din, e_busy;
    logic [4*CW-1:0] e_hit;

    if (!rst) begin
      check("rst_gnt", gnt, 0);
      check("rst_valid", det_valid, 0);
      check("rst_din", det_din, 0);
      check("rst_flush", det_flush, 0);
      check("rst_busy", busy, 0);
      check("rst_hit_cnt", hit_cnt, 0);
      m_phase = 0;
      m_last  = -1;
      m_byte  = '0;
      for (int k = 0; k < 4; k++) m_cnt[k] = 0;
    end else begin
      win = -1;
      if (m_phase == 0 && req != 0)
        for (int k = 0; k < 4; k++)
          if (win < 0 && req[(m_last + 1 + k) % 4]) win = (m_last + 1 + k) % 4;

      e_gnt   = (win >= 0) ? (4'b0001 << win) : 4'b0000;
      e_flush = (win >= 0) && (win != m_last);
      e_valid = (m_phase >= 1 && m_phase <= 8);
      e_din   = e_valid ? m_byte[8 - m_phase] : 1'b0;
      e_busy  = (m_phase >= 1);
      for (int k = 0; k < 4; k++) e_hit[CW*k +: CW] = m_cnt[k][CW-1:0];

      check("gnt", gnt, e_gnt);
      check("flush", det_flush, e_flush);
      check("valid", det_valid, e_valid);
      check("din", det_din, e_din);
      check("busy", busy, e_busy);
      check("hit_cnt", hit_cnt, e_hit);

      // advance the model across the coming rising edge
      if (clr_cnt) begin
        for (int k = 0; k < 4; k++) m_cnt[k] = 0;
      end else if (m_phase >= 1 && det_hit) begin
`ifdef PD_ARB_SAT_EN
        if (m_cnt[m_last] < CMAX) m_cnt[m_last] = m_cnt[m_last] + 1;
`else
        m_cnt[m_last] = (m_cnt[m_last] + 1) % (CMAX + 1);
`endif
      end
      if (win >= 0) begin
        m_byte  = req_data[8*win +: 8];
        m_last  = win;
        m_phase = 1;
      end else if (m_phase >= 1) begin
        m_phase = (m_phase == 9) ? 0 : m_phase + 1;
      end
    end

    for (int k = 0; k < 4; k++) if (gnt[k]) g_log.push_back(k);
    if (det_flush) f_cnt++;
    if (det_valid) din_log.push_back(det_din);
    if (busy) busy_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [7:0] v;
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    rst = 1'b0; req = '0; req_data = '0; det_hit = 1'b0; clr_cnt = 1'b0;
    repeat (3) tick();
    rst = 1'b1;

    // single byte A5 from requester 0; data changes after grant are ignored
    clear_logs();
    req_data = 32'h0000_00A5;
    req      = 4'b0001;
    tick();
    req      = 4'b0000;
    req_data = 32'h1234_5678;
    repeat (11) tick();
    v = '0;
    foreach (din_log[i]) v = {v[6:0], din_log[i]};
    check("a5_bits", din_log.size(), 8);
    check("a5_seq", v, 8'hA5);
    check("a5_busy", busy_cnt, 9);
    check("a5_flush", f_cnt, 1);
    check("a5_grants", g_log.size(), 1);

    // all four requesting: strict rotation, flush on every grant
    reset_dut();
    clear_logs();
    req_data = 32'h3C81_FF00;
    req      = 4'b1111;
    repeat (80) tick();
    req = 4'b0000;
    repeat (2) tick();
    check("rr_count", g_log.size(), 8);
    if (g_log.size() == 8)
      for (int i = 0; i < 8; i++) check("rr_order", g_log[i], exp_order[i]);
    check("rr_flush", f_cnt, 8);

    // same owner re-granted: only the first grant flushes
    clear_logs();
    req_data = 32'h0096_0000;
    req      = 4'b0100;
    repeat (30) tick();
    req = 4'b0000;
    repeat (2) tick();
    check("same_count", g_log.size(), 3);
    foreach (g_log[i]) check("same_owner", g_log[i], 2);
    check("same_flush", f_cnt, 1);

    // owner 1: hit in 3rd SHIFT and in DRAIN counts, hit in IDLE does not
    req_data = 32'h0000_5A00;
    req      = 4'b0010;
    tick();                       // S1
    req = 4'b0000;
    tick();                       // S2
    tick(); det_hit = 1'b1;       // S3
    tick(); det_hit = 1'b0;       // S4
    repeat (4) tick();            // S8
    tick(); det_hit = 1'b1;       // DRAIN
    tick();                       // IDLE
    tick(); det_hit = 1'b0;
    check("hit_owner1", hit_cnt, 64'(2 << CW));

    // five hits on owner 0 with a 2-bit counter
    clr_cnt = 1'b1; tick(); clr_cnt = 1'b0;
    req_data = 32'h0000_00C3;
    req      = 4'b0001;
    tick(); req = 4'b0000; det_hit = 1'b1;   // S1
    repeat (5) tick(); det_hit = 1'b0;       // S6
    repeat (5) tick();
`ifdef PD_ARB_SAT_EN
    check("five_hits", hit_cnt, 3);
`else
    check("five_hits", hit_cnt, 1);
`endif

    // clear and hit in the same cycle: clear wins
    req = 4'b0001;
    tick(); req = 4'b0000; det_hit = 1'b1;   // S1
    tick(); clr_cnt = 1'b1;                  // S2
    tick(); clr_cnt = 1'b0; det_hit = 1'b0;  // S3
    check("clr_wins", hit_cnt, 0);
    repeat (8) tick();

    // reset in the 4th SHIFT cycle, then requester 0 wins after release
    req_data = 32'h0000_F000;
    req      = 4'b0010;
    tick(); req = 4'b0000; det_hit = 1'b1;   // S1
    tick(); det_hit = 1'b0;                  // S2
    tick();                                  // S3
    tick();                                  // S4
    rst = 1'b0;
    #1;
    check("async_valid", det_valid, 0);
    check("async_busy", busy, 0);
    check("async_hit_cnt", hit_cnt, 0);
    req = 4'b1001;
    repeat (2) tick();
    clear_logs();
    rst = 1'b1;
    tick();
    req = 4'b0000;
    repeat (11) tick();
    check("post_rst_grants", g_log.size(), 1);
    if (g_log.size() > 0) check("post_rst_owner", g_log[0], 0);
    check("post_rst_flush", f_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
